// File: rtl/seg_scan_decoder.sv
// Monitor for a multiplexed 7-segment scan bus: filters each digit dwell, decodes it back to hex, and publishes 8-digit frames.
// Optional bus-idle watchdog (scan_lost) is compiled in with `define SEG_DEC_TIMEOUT_EN.
module seg_scan_decoder #(
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DS_ACTIVE_LOW  = 1'b1,
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 65536
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [6:0]  num,
   input  logic [7:0]  DS,
   output logic [31:0] digits,
   output logic [7:0]  blank,
   output logic [7:0]  err,
   output logic        frame_done,
   output logic        scan_lost
);

   localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

   if (STABLE_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("seg_scan_decoder: STABLE_CYCLES must be >= 2 and TIMEOUT_CYCLES >= 1");
   end

   logic [6:0]    num_s1_q, num_s2_q;
   logic [7:0]    ds_s1_q, ds_s2_q;
   logic [6:0]    seg_n;
   logic [7:0]    ds_n;
   logic [14:0]   pat_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          armed_q, armed_d;
   logic          changed, try_cap, onehot, cap;
   logic [2:0]    cap_idx;
   logic [3:0]    dec_val;
   logic          dec_blank, dec_err;
   logic          idle_hit;
   logic [31:0]   stage_val_q, stage_val_d;
   logic [7:0]    stage_blank_q, stage_blank_d;
   logic [7:0]    stage_err_q, stage_err_d;
   logic [7:0]    seen_q, seen_d;
   logic [31:0]   digits_q, digits_d;
   logic [7:0]    blank_q, blank_d;
   logic [7:0]    err_q, err_d;
   logic          frame_done_q, frame_done_d;

   assign seg_n = SEG_ACTIVE_LOW ? ~num_s2_q : num_s2_q;
   assign ds_n  = DS_ACTIVE_LOW ? ~ds_s2_q : ds_s2_q;

   // One capture per dwell: armed stays set until the bus pattern changes.
   always_comb begin
      changed = ({ds_n, seg_n} != pat_q);
      cnt_d   = cnt_q;
      armed_d = armed_q;
      try_cap = 1'b0;
      if (changed) begin
         cnt_d   = '0;
         armed_d = 1'b0;
      end else begin
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_MAX && !armed_q) begin
            try_cap = 1'b1;
            armed_d = 1'b1;
         end
      end
   end

   always_comb begin
      onehot  = (ds_n != 8'd0) && ((ds_n & (ds_n - 8'd1)) == 8'd0);
      cap     = try_cap && onehot;
      cap_idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (ds_n[i]) cap_idx = 3'(i);
      end
   end

   always_comb begin
      dec_val   = 4'h0;
      dec_blank = 1'b0;
      dec_err   = 1'b0;
      case (seg_n)
         7'h3F: dec_val = 4'h0;
         7'h06: dec_val = 4'h1;
         7'h5B: dec_val = 4'h2;
         7'h4F: dec_val = 4'h3;
         7'h66: dec_val = 4'h4;
         7'h6D: dec_val = 4'h5;
         7'h7D: dec_val = 4'h6;
         7'h07: dec_val = 4'h7;
         7'h7F: dec_val = 4'h8;
         7'h6F: dec_val = 4'h9;
         7'h77: dec_val = 4'hA;
         7'h7C: dec_val = 4'hB;
         7'h39: dec_val = 4'hC;
         7'h5E: dec_val = 4'hD;
         7'h79: dec_val = 4'hE;
         7'h71: dec_val = 4'hF;
         7'h00: dec_blank = 1'b1;
         default: dec_err = 1'b1;
      endcase
   end

   // Publishing reads the staging registers before this cycle's capture lands,
   // so a capture in the copy cycle belongs to the next frame.
   always_comb begin
      stage_val_d   = stage_val_q;
      stage_blank_d = stage_blank_q;
      stage_err_d   = stage_err_q;
      seen_d        = seen_q;
      digits_d      = digits_q;
      blank_d       = blank_q;
      err_d         = err_q;
      frame_done_d  = 1'b0;
      if (seen_q == 8'hFF) begin
         digits_d     = stage_val_q;
         blank_d      = stage_blank_q;
         err_d        = stage_err_q;
         frame_done_d = 1'b1;
         seen_d       = '0;
      end
      if (idle_hit && !cap) seen_d = '0;
      if (cap) begin
         stage_val_d[{cap_idx, 2'b00} +: 4] = dec_val;
         stage_blank_d[cap_idx]             = dec_blank;
         stage_err_d[cap_idx]               = dec_err;
         seen_d[cap_idx]                    = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         num_s1_q      <= '0;
         num_s2_q      <= '0;
         ds_s1_q       <= '0;
         ds_s2_q       <= '0;
         pat_q         <= '0;
         cnt_q         <= '0;
         armed_q       <= 1'b0;
         stage_val_q   <= '0;
         stage_blank_q <= '0;
         stage_err_q   <= '0;
         seen_q        <= '0;
         digits_q      <= '0;
         blank_q       <= '0;
         err_q         <= '0;
         frame_done_q  <= 1'b0;
      end else begin
         num_s1_q      <= num;
         num_s2_q      <= num_s1_q;
         ds_s1_q       <= DS;
         ds_s2_q       <= ds_s1_q;
         pat_q         <= {ds_n, seg_n};
         cnt_q         <= cnt_d;
         armed_q       <= armed_d;
         stage_val_q   <= stage_val_d;
         stage_blank_q <= stage_blank_d;
         stage_err_q   <= stage_err_d;
         seen_q        <= seen_d;
         digits_q      <= digits_d;
         blank_q       <= blank_d;
         err_q         <= err_d;
         frame_done_q  <= frame_done_d;
      end
   end

`ifdef SEG_DEC_TIMEOUT_EN
   localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);

   logic [IW-1:0] idle_q, idle_d;
   logic          scan_lost_q, scan_lost_d;

   // Idle counter saturates at the limit, holding seen cleared until traffic returns.
   always_comb begin
      idle_hit    = (idle_q == IDLE_MAX);
      idle_d      = idle_q;
      scan_lost_d = scan_lost_q;
      if (cap) begin
         idle_d      = '0;
         scan_lost_d = 1'b0;
      end else if (idle_hit) begin
         scan_lost_d = 1'b1;
      end else begin
         idle_d = idle_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_q      <= '0;
         scan_lost_q <= 1'b0;
      end else begin
         idle_q      <= idle_d;
         scan_lost_q <= scan_lost_d;
      end
   end

   assign scan_lost = scan_lost_q;
`else
   assign idle_hit  = 1'b0;
   assign scan_lost = 1'b0;
`endif

   assign digits     = digits_q;
   assign blank      = blank_q;
   assign err        = err_q;
   assign frame_done = frame_done_q;

endmodule
